// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch port
//   (read-only) and the data port (read/write). Accesses are serialised by
//   an IDLE -> BUSY -> RESP state machine. The winning requester gets a
//   one-cycle acknowledge. A watchdog aborts accesses that the memory never
//   acknowledges.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   if_req/if_addr            fetch request, held until if_ack
//   if_data/if_ack            fetched word and one-cycle completion pulse
//   dm_ren/dm_wen/dm_addr     data request (a write wins over a read), held
//   dm_din                    write data
//   dm_dout/dm_ack            read data and one-cycle completion pulse
//   mem_cs/mem_we/mem_addr    memory-side request, stable through BUSY
//   mem_dout                  memory write data
//   mem_din/mem_ack           memory read data and done (BUSY only)
//   if_stall/mem_stall        pipeline stall flags (combinational)
//   acc_err                   current ack was produced by a timeout abort
//   bus_err                   sticky timeout flag, cleared only by reset
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_data,
    output logic                  if_ack,
    input  logic                  dm_ren,
    input  logic                  dm_wen,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_din,
    output logic [DATA_WIDTH-1:0] dm_dout,
    output logic                  dm_ack,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_dout,
    input  logic [DATA_WIDTH-1:0] mem_din,
    input  logic                  mem_ack,
    output logic                  if_stall,
    output logic                  mem_stall,
    output logic                  acc_err,
    output logic                  bus_err
);

    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             gnt;   // 0 = fetch, 1 = data
    logic             last;  // port granted by the previous access
    logic [CNT_W-1:0] cnt;
    logic             dm_req;
    logic             pick;  // port to grant if IDLE sees a request

    assign dm_req    = dm_ren | dm_wen;
    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = dm_req & ~dm_ack;

    // On a conflict the port that did not win last time is served, so the
    // two ports alternate under sustained contention.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        pick = 1'b0;
        if (if_req && dm_req) pick = ~last;
        else                  pick = dm_req;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last     <= 1'b0;
            cnt      <= '0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_dout <= '0;
            if_data  <= '0;
            dm_dout  <= '0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            acc_err  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        gnt      <= pick;
                        mem_cs   <= 1'b1;
                        mem_we   <= pick & dm_wen;
                        mem_addr <= pick ? dm_addr : if_addr;
                        mem_dout <= pick ? dm_din : '0;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        // A real completion wins over a timeout in the same cycle.
                        mem_cs  <= 1'b0;
                        acc_err <= 1'b0;
                        if (!mem_we) begin
                            if (gnt) dm_dout <= mem_din;
                            else     if_data <= mem_din;
                        end
                        if (gnt) dm_ack <= 1'b1;
                        else     if_ack <= 1'b1;
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        // Abort: the requester sees zero read data and acc_err.
                        mem_cs  <= 1'b0;
                        acc_err <= 1'b1;
                        bus_err <= 1'b1;
                        if (!mem_we) begin
                            if (gnt) dm_dout <= '0;
                            else     if_data <= '0;
                        end
                        if (gnt) dm_ack <= 1'b1;
                        else     if_ack <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Requests are not looked at here, so a request held
                    // through its ack cycle is only seen again in IDLE.
                    if_ack  <= 1'b0;
                    dm_ack  <= 1'b0;
                    acc_err <= 1'b0;
                    last    <= gnt;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
